hue_pwm_engine: RTL and testbench

Parametrised RGB LED colour engine and the next generation of the board's hue-cycling PWM driver. It generates three PWM outputs from a hue/brightness state and adds runtime modes: off, continuous hue cycle, fixed hue and breathe. It also adds global brightness scaling, glitch-free duty updates at PWM period boundaries, and a valid/ready configuration port for the top level or a future UART/button controller.

---
 rtl/hue_pwm_pkg.sv | 22 ++
 rtl/hue_to_rgb.sv | 81 ++++++++
 rtl/hue_pwm_engine.sv | 179 +++++++++++++++++
 tb/tb_hue_pwm_engine.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hue_pwm_pkg.sv
// Shared types and constants for the hue-cycling RGB PWM engine.
package hue_pwm_pkg;

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_CYCLE   = 2'b01,
        MODE_FIXED   = 2'b10,
        MODE_BREATHE = 2'b11
    } mode_t;

    localparam logic [8:0] HUE_MAX    = 9'd359;
    localparam logic [8:0] SECTOR_DEG = 9'd60;

    // Colour-wheel sector index, 0..5, one per 60 degrees.
    typedef logic [2:0] sector_t;

    // Out-of-range hues saturate at the last valid degree.
    function automatic logic [8:0] clamp_hue(input logic [8:0] h);
        return (h > HUE_MAX) ? HUE_MAX : h;
    endfunction

endpackage

// File: rtl/hue_to_rgb.sv
// Hue/level to RGB duty mapper: stage 1 decodes the sector and builds the
// linear ramps, stage 2 scales the ramps by (level+1) >> PWM_BITS.
module hue_to_rgb
    import hue_pwm_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [8:0]          hue,
    input  logic [PWM_BITS-1:0] level,
    output logic [PWM_BITS-1:0] duty_r,
    output logic [PWM_BITS-1:0] duty_g,
    output logic [PWM_BITS-1:0] duty_b
);

    localparam int                  PROD_W = PWM_BITS + 9;
    localparam logic [PWM_BITS-1:0] MAX_V  = '1;

    // floor(MAX * x / 60); x never exceeds 60 so the result fits PWM_BITS.
    function automatic logic [PWM_BITS-1:0] ramp(input logic [8:0] x);
        return PWM_BITS'(({9'd0, MAX_V} * {{PWM_BITS{1'b0}}, x}) / PROD_W'(SECTOR_DEG));
    endfunction

    sector_t             sec;
    logic [PWM_BITS-1:0] r_c, g_c, b_c;
    logic [PWM_BITS-1:0] r_q, g_q, b_q, lvl_q;
    logic [PWM_BITS:0]   lvl_p1;

    // Sector decode and per-channel ramp selection.
    always_comb begin
        r_c = '0;
        g_c = '0;
        b_c = '0;
        if      (hue < 9'd60)  sec = 3'd0;
        else if (hue < 9'd120) sec = 3'd1;
        else if (hue < 9'd180) sec = 3'd2;
        else if (hue < 9'd240) sec = 3'd3;
        else if (hue < 9'd300) sec = 3'd4;
        else                   sec = 3'd5;
        case (sec)
            3'd0: begin r_c = MAX_V;               g_c = ramp(hue);                          end
            3'd1: begin r_c = ramp(9'd120 - hue);  g_c = MAX_V;                              end
            3'd2: begin g_c = MAX_V;               b_c = ramp(hue - 9'd120);                 end
            3'd3: begin g_c = ramp(9'd240 - hue);  b_c = MAX_V;                              end
            3'd4: begin r_c = ramp(hue - 9'd240);  b_c = MAX_V;                              end
            default: begin r_c = MAX_V;            b_c = ramp(9'd360 - hue);                 end
        endcase
    end

    // Stage 1: register the unscaled ramps together with the level they pair with.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            lvl_q <= '0;
        end else begin
            r_q   <= r_c;
            g_q   <= g_c;
            b_q   <= b_c;
            lvl_q <= level;
        end
    end

    assign lvl_p1 = {1'b0, lvl_q} + (PWM_BITS+1)'(1);

    // Stage 2: brightness multiply; level = MAX gives ramp*2^N >> N, the identity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_r <= '0;
            duty_g <= '0;
            duty_b <= '0;
        end else begin
            duty_r <= PWM_BITS'(({{(PWM_BITS+1){1'b0}}, r_q} * {{PWM_BITS{1'b0}}, lvl_p1}) >> PWM_BITS);
            duty_g <= PWM_BITS'(({{(PWM_BITS+1){1'b0}}, g_q} * {{PWM_BITS{1'b0}}, lvl_p1}) >> PWM_BITS);
            duty_b <= PWM_BITS'(({{(PWM_BITS+1){1'b0}}, b_q} * {{PWM_BITS{1'b0}}, lvl_p1}) >> PWM_BITS);
        end
    end

endmodule

// File: rtl/hue_pwm_engine.sv
// RGB LED colour engine: free-running PWM with period-boundary duty updates,
// off/cycle/fixed/breathe modes and a shadowed valid/ready config port.
// rst_n is asserted asynchronously and is expected to be released
// synchronously to clk by the board reset generator.
//
// Config handshake: a transfer happens on a clk edge where cfg_valid and
// cfg_ready are both high; cfg_mode/cfg_hue/cfg_bright are sampled on that
// edge. cfg_ready then stays low until the cycle after the shadow has been
// applied at a PWM wrap. Offers made while cfg_ready is low are not taken
// and are not remembered, so cfg_valid may be raised or dropped at any time.
module hue_pwm_engine
    import hue_pwm_pkg::*;
#(
    parameter int         CLK_FREQ      = 12000000,
    parameter int         PWM_BITS      = 8,
    parameter int         STEP_CYCLES   = CLK_FREQ / 360,
    parameter int         BREATH_CYCLES = CLK_FREQ / 512,
    parameter logic [1:0] RESET_MODE    = 2'b01
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [1:0]          cfg_mode,
    input  logic [8:0]          cfg_hue,
    input  logic [PWM_BITS-1:0] cfg_bright,
    output logic [8:0]          hue_out,
    output logic                period_start,
    output logic                RGB_R,
    output logic                RGB_G,
    output logic                RGB_B
);

    localparam int                  SW    = (STEP_CYCLES   > 1) ? $clog2(STEP_CYCLES)   : 1;
    localparam int                  BW    = (BREATH_CYCLES > 1) ? $clog2(BREATH_CYCLES) : 1;
    localparam logic [PWM_BITS-1:0] MAX_V = '1;

    // Complete engine state in one struct so it can be observed as a unit.
    typedef struct packed {
        mode_t               mode;
        logic [PWM_BITS-1:0] bright;
        logic [8:0]          hue;
        logic [SW-1:0]       step_cnt;
        logic [BW-1:0]       brth_cnt;
        logic [PWM_BITS-1:0] brth_lvl;
        logic                brth_down;
        logic                pend;
        logic                rdy;
        mode_t               sh_mode;
        logic [PWM_BITS-1:0] sh_bright;
        logic [8:0]          sh_hue;
    } eng_t;

    eng_t                st_q, st_d;
    logic [PWM_BITS-1:0] cnt;
    logic                wrap;
    logic                accept;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] nxt_r, nxt_g, nxt_b;
    logic [PWM_BITS-1:0] duty_r_q, duty_g_q, duty_b_q;
    logic                period_start_q;

    assign wrap   = (cnt == MAX_V);
    assign accept = cfg_valid && st_q.rdy;

    // Engine state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= '0;
            st_q.mode   <= mode_t'(RESET_MODE);
            st_q.bright <= MAX_V;
            st_q.rdy    <= 1'b1;
        end else begin
            st_q <= st_d;
        end
    end

    // Next state: config capture/apply, hue stepping and breathe triangle.
    always_comb begin
        st_d     = st_q;
        st_d.rdy = !(st_q.pend || accept);
        if (accept) begin
            st_d.pend      = 1'b1;
            st_d.sh_mode   = mode_t'(cfg_mode);
            st_d.sh_bright = cfg_bright;
            st_d.sh_hue    = clamp_hue(cfg_hue);
        end
        if (wrap && st_q.pend) begin
            st_d.pend      = 1'b0;
            st_d.mode      = st_q.sh_mode;
            st_d.bright    = st_q.sh_bright;
            st_d.hue       = st_q.sh_hue;
            st_d.step_cnt  = '0;
            st_d.brth_cnt  = '0;
            st_d.brth_lvl  = '0;
            st_d.brth_down = 1'b0;
        end else begin
            case (st_q.mode)
                MODE_CYCLE: begin
                    if (st_q.step_cnt == SW'(STEP_CYCLES - 1)) begin
                        st_d.step_cnt = '0;
                        st_d.hue      = (st_q.hue == HUE_MAX) ? 9'd0 : st_q.hue + 9'd1;
                    end else begin
                        st_d.step_cnt = st_q.step_cnt + SW'(1);
                    end
                end
                MODE_BREATHE: begin
                    if (st_q.brth_cnt == BW'(BREATH_CYCLES - 1)) begin
                        st_d.brth_cnt = '0;
                        if (!st_q.brth_down) begin
                            if (st_q.brth_lvl == st_q.bright) st_d.brth_down = 1'b1;
                            else                              st_d.brth_lvl  = st_q.brth_lvl + PWM_BITS'(1);
                        end else begin
                            if (st_q.brth_lvl == '0) st_d.brth_down = 1'b0;
                            else                     st_d.brth_lvl  = st_q.brth_lvl - PWM_BITS'(1);
                        end
                    end else begin
                        st_d.brth_cnt = st_q.brth_cnt + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Brightness fed to the colour mapper for the current mode.
    always_comb begin
        level = st_q.bright;
        case (st_q.mode)
            MODE_OFF:     level = '0;
            MODE_BREATHE: level = st_q.brth_lvl;
            default:      level = st_q.bright;
        endcase
    end

    hue_to_rgb #(
        .PWM_BITS (PWM_BITS)
    ) u_hue_to_rgb (
        .clk    (clk),
        .rst_n  (rst_n),
        .hue    (st_q.hue),
        .level  (level),
        .duty_r (nxt_r),
        .duty_g (nxt_g),
        .duty_b (nxt_b)
    );

    // Free-running PWM counter and the registered period-start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            period_start_q <= 1'b0;
        end else begin
            cnt            <= cnt + PWM_BITS'(1);
            period_start_q <= wrap;
        end
    end

    // Duty latches only move on the MAX->0 edge so a period is never split.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_r_q <= '0;
            duty_g_q <= '0;
            duty_b_q <= '0;
        end else if (wrap) begin
            duty_r_q <= nxt_r;
            duty_g_q <= nxt_g;
            duty_b_q <= nxt_b;
        end
    end

    assign RGB_R        = (cnt < duty_r_q);
    assign RGB_G        = (cnt < duty_g_q);
    assign RGB_B        = (cnt < duty_b_q);
    assign period_start = period_start_q;
    assign cfg_ready    = st_q.rdy;
    assign hue_out      = st_q.hue;

endmodule

// File: tb/tb_hue_pwm_engine.sv
// Self-checking bench for hue_pwm_engine with a cycle-index based reference model.
module tb_hue_pwm_engine;

    localparam int PER    = 256;
    localparam int STEP   = 4;
    localparam int BREATH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_mode = 2'd0;
    logic [8:0] cfg_hue = 9'd0;
    logic [7:0] cfg_bright = 8'd0;
    logic       cfg_ready, period_start, RGB_R, RGB_G, RGB_B;
    logic [8:0] hue_out;

    int total = 0;
    int bad   = 0;
    bit started = 1'b0;

    hue_pwm_engine #(
        .CLK_FREQ      (12000000),
        .PWM_BITS      (8),
        .STEP_CYCLES   (STEP),
        .BREATH_CYCLES (BREATH),
        .RESET_MODE    (2'b01)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_mode     (cfg_mode),
        .cfg_hue      (cfg_hue),
        .cfg_bright   (cfg_bright),
        .hue_out      (hue_out),
        .period_start (period_start),
        .RGB_R        (RGB_R),
        .RGB_G        (RGB_G),
        .RGB_B        (RGB_B)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, expv);
        end
    endtask

    // ---------------- reference model ----------------
    // k counts clock edges since reset release; an "epoch" is the settings
    // in force from edge ep_k onward, so hue and level are closed-form in k.
    int         k, ep_k, ep_mode, ep_hue, ep_bright;
    bit         pend;
    int         pd_mode, pd_hue, pd_bright, last_apply;
    int         h_cur, l_cur, h_prev, l_prev;
    logic [23:0] dn_cur, lat, dn_new;
    logic [13:0] exp_q[$];
    bit         m_acc;
    int         m_nk;

    function automatic int ramp60(input int x);
        return (255 * x) / 60;
    endfunction

    function automatic logic [23:0] colour(input int h, input int lvl);
        int r, g, b;
        r = 0; g = 0; b = 0;
        if      (h < 60)  begin r = 255;              g = ramp60(h);        end
        else if (h < 120) begin r = ramp60(120 - h);  g = 255;              end
        else if (h < 180) begin g = 255;              b = ramp60(h - 120);  end
        else if (h < 240) begin g = ramp60(240 - h);  b = 255;              end
        else if (h < 300) begin r = ramp60(h - 240);  b = 255;              end
        else              begin r = 255;              b = ramp60(360 - h);  end
        return {8'(r * (lvl + 1) / 256), 8'(g * (lvl + 1) / 256), 8'(b * (lvl + 1) / 256)};
    endfunction

    // Triangle 0..b..0 with each endpoint held for one extra step.
    function automatic int tri_level(input int n, input int b);
        int p;
        p = n % (2 * b + 2);
        return (p <= b) ? p : 2 * b + 1 - p;
    endfunction

    function automatic int model_hue(input int kk);
        if (ep_mode == 1) return (ep_hue + (kk - ep_k) / STEP) % 360;
        return ep_hue;
    endfunction

    function automatic int model_lvl(input int kk);
        if (ep_mode == 0) return 0;
        if (ep_mode == 3) return tri_level((kk - ep_k) / BREATH, ep_bright);
        return ep_bright;
    endfunction

    function automatic bit model_ready();
        return !pend && (k != last_apply);
    endfunction

    function automatic logic [13:0] exp_vec();
        int c;
        c = k % PER;
        return {9'(h_cur), model_ready(), (k > 0 && c == 0),
                (c < int'(lat[23:16])), (c < int'(lat[15:8])), (c < int'(lat[7:0]))};
    endfunction

    task automatic model_reset();
        k = 0; ep_k = 0; ep_mode = 1; ep_hue = 0; ep_bright = 255;
        pend = 0; pd_mode = 0; pd_hue = 0; pd_bright = 0; last_apply = -1;
        h_cur = 0; l_cur = 255; h_prev = 0; l_prev = 0;
        dn_cur = '0; lat = '0;
    endtask

    // Model advance: one step per clock edge, expectation queued for the compare.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            m_acc = cfg_valid && model_ready();
            m_nk  = k + 1;
            if (pend && (m_nk % PER == 0)) begin
                ep_k = m_nk; ep_mode = pd_mode; ep_hue = pd_hue; ep_bright = pd_bright;
                pend = 0; last_apply = m_nk;
            end
            if (m_acc) begin
                pend      = 1;
                pd_mode   = int'(cfg_mode);
                pd_hue    = (int'(cfg_hue) > 359) ? 359 : int'(cfg_hue);
                pd_bright = int'(cfg_bright);
            end
            dn_new = (m_nk >= 2) ? colour(h_prev, l_prev) : 24'h0;
            if (m_nk % PER == 0) lat = dn_cur;
            dn_cur = dn_new;
            h_prev = h_cur; l_prev = l_cur;
            k = m_nk;
            h_cur = model_hue(k);
            l_cur = model_lvl(k);
        end
        exp_q.delete();
        exp_q.push_back(exp_vec());
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [13:0] a_vec, e_vec;
        if (started) begin
            a_vec = {hue_out, cfg_ready, period_start, RGB_R, RGB_G, RGB_B};
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL model_queue: got empty required one entry");
            end else begin
                e_vec = exp_q.pop_front();
                check($sformatf("cycle k=%0d {hue,rdy,ps,r,g,b}", k), int'(a_vec), int'(e_vec));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_cfg(input int m, input int h, input int b);
        int w;
        w = 0;
        while (!cfg_ready && w < 3 * PER) begin @(negedge clk); w++; end
        check("ready_before_send", int'(cfg_ready), 1);
        cfg_mode = 2'(m); cfg_hue = 9'(h); cfg_bright = 8'(b); cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_apply();
        int w;
        w = 0;
        while (!cfg_ready && w < 3 * PER) begin @(negedge clk); w++; end
        check("apply_timeout", int'(cfg_ready), 1);
    endtask

    task automatic wait_period();
        int w;
        w = 0;
        @(negedge clk);
        while (!period_start && w < PER + 5) begin @(negedge clk); w++; end
        check("period_timeout", int'(period_start), 1);
    endtask

    task automatic measure(output int nr, output int ng, output int nb);
        wait_period();
        nr = 0; ng = 0; nb = 0;
        for (int i = 0; i < PER; i++) begin
            nr += int'(RGB_R); ng += int'(RGB_G); nb += int'(RGB_B);
            @(negedge clk);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int nr, ng, nb, hz, ones, w;
        bit seen359, wrapped;

        // Pin the model against hand-computed values.
        check("pin_colour_90_255",  int'(colour(90, 255)),  int'(24'h7FFF00));
        check("pin_colour_0_127",   int'(colour(0, 127)),   int'(24'h7F0000));
        check("pin_colour_240_4",   int'(colour(240, 4)),   int'(24'h000004));
        check("pin_colour_330_255", int'(colour(330, 255)), int'(24'hFF007F));
        check("pin_colour_359_255", int'(colour(359, 255)), int'(24'hFF0004));
        check("pin_tri_3_2", tri_level(3, 2), 2);
        check("pin_tri_6_2", tri_level(6, 2), 0);
        check("pin_tri_5_0", tri_level(5, 0), 0);

        // Reset for 5 clocks, release on a falling edge.
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        started = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // First period: nothing latched yet, all outputs low.
        ones = 0;
        for (int i = 0; i < 250; i++) begin
            ones += int'(RGB_R) + int'(RGB_G) + int'(RGB_B);
            @(negedge clk);
        end
        check("first_period_dark", ones, 0);

        // Continuous cycle: observe the 359 -> 0 hue wrap.
        seen359 = 0; wrapped = 0; w = 0;
        while (!wrapped && w < 1600) begin
            if (hue_out == 9'd359) seen359 = 1;
            else if (seen359 && hue_out == 9'd0) wrapped = 1;
            @(negedge clk); w++;
        end
        check("hue_wrap_seen", int'(wrapped), 1);

        // Fixed hue 90 at full brightness.
        send_cfg(2, 90, 255);
        check("ready_low_after_accept", int'(cfg_ready), 0);
        wait_apply();
        check("fixed90_hue", int'(hue_out), 90);
        measure(nr, ng, nb);
        check("fixed90_r", nr, 127);
        check("fixed90_g", ng, 255);
        check("fixed90_b", nb, 0);

        // Fixed hue 0 at half brightness, then zero brightness.
        send_cfg(2, 0, 127);
        wait_apply();
        measure(nr, ng, nb);
        check("fixed0_b127_r", nr, 127);
        check("fixed0_b127_gb", ng + nb, 0);
        send_cfg(2, 0, 0);
        wait_apply();
        measure(nr, ng, nb);
        check("fixed0_b0_all", nr + ng + nb, 0);

        // Breathe at hue 240 with a small peak.
        send_cfg(3, 240, 4);
        wait_apply();
        tick(600);
        check("breathe_hue_held", int'(hue_out), 240);

        // Offer landing exactly on the wrap edge, followed by an ignored offer.
        wait_period();
        tick(PER - 1);
        check("ready_at_wrap_offer", int'(cfg_ready), 1);
        cfg_mode = 2'd2; cfg_hue = 9'd180; cfg_bright = 8'd255; cfg_valid = 1'b1;
        @(negedge clk);
        cfg_mode = 2'd2; cfg_hue = 9'd0; cfg_bright = 8'd255;
        tick(3);
        cfg_valid = 1'b0;
        tick(200);
        check("wrap_offer_not_applied_ready", int'(cfg_ready), 0);
        check("wrap_offer_not_applied_hue", int'(hue_out), 240);
        wait_apply();
        check("wrap_offer_applied_hue", int'(hue_out), 180);
        measure(nr, ng, nb);
        check("fixed180_r", nr, 0);
        check("fixed180_g", ng, 255);
        check("fixed180_b", nb, 255);

        // Async reset mid-period drops the pending config.
        send_cfg(2, 60, 255);
        tick(50);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_rgb", int'({RGB_R, RGB_G, RGB_B}), 0);
        check("async_rst_ready", int'(cfg_ready), 1);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        check("after_rst_cycle_hue", int'(hue_out), 5);
        tick(700);

        // Off mode for three periods with hue frozen.
        send_cfg(0, 100, 200);
        wait_apply();
        hz = int'(hue_out);
        ones = 0;
        for (int p = 0; p < 3; p++) begin
            measure(nr, ng, nb);
            ones += nr + ng + nb;
        end
        check("off_all_low", ones, 0);
        check("off_hue_frozen", int'(hue_out), hz);
        check("off_hue_value", hz, 100);

        // Out-of-range hue clamps.
        send_cfg(2, 400, 255);
        wait_apply();
        check("hue_clamp", int'(hue_out), 359);

        // Randomised config traffic, checked every cycle by the model.
        for (int it = 0; it < 8; it++) begin
            for (int c = 0; c < 300; c++) begin
                cfg_valid  = ($urandom_range(0, 9) == 0);
                cfg_mode   = 2'($urandom_range(0, 3));
                cfg_hue    = 9'($urandom_range(0, 450));
                cfg_bright = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 6))
                                                         : 8'($urandom_range(0, 255));
                @(negedge clk);
            end
            cfg_valid = 1'b0;
            tick(600);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
